// File: rtl/fetch_pkg.sv
// Shared opcode constants, field bounds and sequencer states for the fetch unit.
// Instruction format: opcode in the top six bits, immediate target/offset in the low ten.
package fetch_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int IMM_HI = 9;
    localparam int IMM_LO = 0;

    typedef logic [OPC_HI-OPC_LO:0] opcode_t;

    localparam opcode_t OP_JUMP       = 6'b010010;
    localparam opcode_t OP_BZ         = 6'b010000;
    localparam opcode_t OP_PRE_BRANCH = 6'b001111;
    localparam opcode_t OP_INPUT      = 6'b011000;
    localparam opcode_t OP_HALT       = 6'b111111;

    typedef enum logic [2:0] {
        INIT,
        RUN,
        WAIT_FLAG,
        WAIT_INPUT,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection; zero latency, stall freezes the PC only in RUN
// (branch/input resolution in the wait states proceeds regardless of stall).
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  fetch_state_t          state,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  pc_ok,
    input  opcode_t               opcode,
    input  logic [ADDR_WIDTH-1:0] imm,
    input  logic [ADDR_WIDTH-1:0] imm_latched,
    input  logic                  stall,
    input  logic                  flag_valid,
    input  logic                  flag_zero,
    input  logic                  input_done,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        case (state)
            RUN: begin
                if (!stall && pc_ok) begin
                    case (opcode)
                        OP_JUMP:                  next_pc = imm;
                        OP_BZ, OP_INPUT, OP_HALT: next_pc = pc;
                        default:                  next_pc = pc + ADDR_WIDTH'(1);
                    endcase
                end
            end
            // Offset is relative to the BZ's own address and wraps modulo 2^ADDR_WIDTH.
            WAIT_FLAG: begin
                if (flag_valid)
                    next_pc = flag_zero ? pc + imm_latched : pc + ADDR_WIDTH'(1);
            end
            WAIT_INPUT: begin
                if (input_done)
                    next_pc = pc + ADDR_WIDTH'(1);
            end
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC sequencer in front of the instruction RAM; issues a word one cycle after its address.
// stall holds PC/instr_out/instr_valid; BZ and INPUT park the PC until execute signals completion.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PROG_DEPTH = 56,
    parameter int RESET_PC   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] instr_in,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_valid,
    input  logic                  stall,
    input  logic                  flag_valid,
    input  logic                  flag_zero,
    input  logic                  input_done,
    output logic                  halted
);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [ADDR_WIDTH-1:0] imm;
    logic [ADDR_WIDTH-1:0] imm_latched;
    opcode_t               opcode;
    logic                  pc_ok;
    logic                  issue;
    logic                  vld_nxt;

    assign opcode  = instr_in[OPC_HI:OPC_LO];
    assign imm     = ADDR_WIDTH'(instr_in[IMM_HI:IMM_LO]);
    assign address = pc;
    // One extra bit so a PROG_DEPTH of 2^ADDR_WIDTH still compares correctly.
    assign pc_ok   = {1'b0, pc} < (ADDR_WIDTH+1)'(PROG_DEPTH);

    fetch_next_pc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_pc (
        .state       (state),
        .pc          (pc),
        .pc_ok       (pc_ok),
        .opcode      (opcode),
        .imm         (imm),
        .imm_latched (imm_latched),
        .stall       (stall),
        .flag_valid  (flag_valid),
        .flag_zero   (flag_zero),
        .input_done  (input_done),
        .next_pc     (pc_nxt)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= INIT;
            pc    <= ADDR_WIDTH'(RESET_PC);
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: state_nxt = RUN;
            RUN: begin
                if (!stall) begin
                    if (!pc_ok)
                        state_nxt = HALT;
                    else if (opcode == OP_BZ)
                        state_nxt = WAIT_FLAG;
                    else if (opcode == OP_INPUT)
                        state_nxt = WAIT_INPUT;
                    else if (opcode == OP_HALT)
                        state_nxt = HALT;
                end
            end
            WAIT_FLAG:  if (flag_valid) state_nxt = RUN;
            WAIT_INPUT: if (input_done) state_nxt = RUN;
            HALT:       state_nxt = HALT;
            default:    state_nxt = INIT;
        endcase
    end

    always_comb begin
        issue   = (state == RUN) && !stall && pc_ok;
        halted  = (state == HALT);
        vld_nxt = instr_valid;
        case (state)
            INIT:    vld_nxt = 1'b0;
            RUN:     if (!stall) vld_nxt = pc_ok;
            default: if (!stall) vld_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            instr_out   <= '0;
            instr_valid <= 1'b0;
            imm_latched <= '0;
        end else begin
            instr_valid <= vld_nxt;
            if (issue) begin
                instr_out   <= instr_in;
                imm_latched <= imm;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed walk through the fetch scenarios, then random
// programs and handshake traffic compared cycle by cycle against a behavioural fetch model.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 55;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  address;
    logic [31:0] instr_in;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        flag_valid = 1'b0;
    logic        flag_zero = 1'b0;
    logic        input_done = 1'b0;
    logic        halted;

    logic [31:0] ram [1024];
    assign instr_in = ram[address];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural PC, what downstream currently sees, and what the unit awaits.
    logic [9:0]  m_pc;
    logic [31:0] m_out;
    logic        m_vld;
    logic        m_halted;
    logic        m_booting;
    logic        m_await_flag;
    logic        m_await_input;
    logic [9:0]  m_off;

    instruction_fetch_unit #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .PROG_DEPTH (DEPTH),
        .RESET_PC   (0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .instr_in    (instr_in),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .stall       (stall),
        .flag_valid  (flag_valid),
        .flag_zero   (flag_zero),
        .input_done  (input_done),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] w;
        logic [5:0]  op;
        if (!reset) begin
            m_pc = 10'd0; m_out = 32'd0; m_vld = 1'b0; m_halted = 1'b0;
            m_booting = 1'b1; m_await_flag = 1'b0; m_await_input = 1'b0;
        end else if (m_booting) begin
            m_booting = 1'b0;
            m_vld = 1'b0;
        end else if (m_halted) begin
            if (!stall) m_vld = 1'b0;
        end else if (m_await_flag || m_await_input) begin
            if (!stall) m_vld = 1'b0;
            if (m_await_flag && flag_valid) begin
                m_pc = flag_zero ? m_pc + m_off : m_pc + 10'd1;
                m_await_flag = 1'b0;
            end else if (m_await_input && input_done) begin
                m_pc = m_pc + 10'd1;
                m_await_input = 1'b0;
            end
        end else if (!stall) begin
            if (int'(m_pc) >= DEPTH) begin
                m_vld = 1'b0;
                m_halted = 1'b1;
            end else begin
                w = ram[m_pc];
                op = w[31:26];
                m_out = w;
                m_vld = 1'b1;
                if (op == 6'b010010)      m_pc = w[9:0];
                else if (op == 6'b010000) begin m_await_flag = 1'b1; m_off = w[9:0]; end
                else if (op == 6'b011000) m_await_input = 1'b1;
                else if (op == 6'b111111) m_halted = 1'b1;
                else                      m_pc = m_pc + 10'd1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("address", 32'(address), 32'(m_pc));
        check("instr_out", instr_out, m_out);
        check("instr_valid", 32'(instr_valid), 32'(m_vld));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_flag(input logic z);
        flag_valid = 1'b1; flag_zero = z;
        tick();
        flag_valid = 1'b0; flag_zero = 1'b0;
    endtask

    task automatic pulse_input();
        input_done = 1'b1;
        tick();
        input_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 11);
        case (r)
            0, 1: w[31:26] = 6'b010010;
            2: begin
                w[31:26] = 6'b010000;
                if ($urandom_range(0, 3) == 0) w[9:0] = 10'(1024 - $urandom_range(1, 8));
                else                           w[9:0] = 10'($urandom_range(0, 20));
            end
            3: w[31:26] = 6'b001111;
            4: w[31:26] = 6'b011000;
            5: w[31:26] = ($urandom_range(0, 3) == 0) ? 6'b111111 : 6'b000001;
            default: begin
                if (w[31:26] inside {6'b010010, 6'b010000, 6'b011000, 6'b111111})
                    w[31:26] = 6'b000010;
            end
        endcase
        if (w[31:26] == 6'b010010) w[9:0] = 10'($urandom_range(0, 60));
        return w;
    endfunction

    initial begin
        int halt_cycles;
        for (int i = 0; i < 1024; i++) ram[i] = {6'b000001, 26'(i * 7 + 3)};
        ram[0]  = 32'h4800_0008;
        ram[11] = 32'h6020_0000;
        ram[12] = 32'h4800_0031;
        ram[49] = 32'h4000_0006;
        ram[51] = 32'h4800_0031;

        // Reset and the INIT bubble.
        tick();
        check("rst_address", 32'(address), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        reset = 1'b1;
        tick();
        check("init_address", 32'(address), 32'd0);
        check("init_valid", 32'(instr_valid), 32'd0);
        tick();
        check("first_word", instr_out, 32'h4800_0008);
        check("first_valid", 32'(instr_valid), 32'd1);
        check("jump_target", 32'(address), 32'd8);

        // Sequential fetch 8..10, then INPUT at 11 with a stray flag pulse in the wait.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_word", instr_out, ram[8 + i]);
            check("seq_address", 32'(address), 32'(9 + i));
        end
        tick();
        check("input_issue", instr_out, 32'h6020_0000);
        tick();
        pulse_flag(1'b1);
        ticks(2);
        check("input_hold", 32'(address), 32'd11);
        check("input_bubble", 32'(instr_valid), 32'd0);
        pulse_input();
        check("input_done", 32'(address), 32'd12);
        ticks(2);
        check("bz_issue", instr_out, 32'h4000_0006);
        ticks(2);
        check("bz_hold", 32'(address), 32'd49);
        check("bz_bubble", 32'(instr_valid), 32'd0);
        pulse_flag(1'b1);
        check("bz_taken", 32'(address), 32'd55);
        tick();
        check("bz_halted", 32'(halted), 32'd1);
        check("bz_halt_valid", 32'(instr_valid), 32'd0);
        ticks(3);

        // Branch not taken, then stall in RUN, then reset during WAIT_FLAG.
        do_reset();
        ticks(4);
        tick();
        tick();
        pulse_input();
        ticks(2);
        ticks(2);
        pulse_flag(1'b0);
        check("bz_not_taken", 32'(address), 32'd50);
        tick();
        check("nt_word", instr_out, ram[50]);
        check("nt_valid", 32'(instr_valid), 32'd1);
        stall = 1'b1;
        ticks(3);
        check("stall_address", 32'(address), 32'd51);
        check("stall_word", instr_out, ram[50]);
        stall = 1'b0;
        ticks(3);
        check("wait_before_rst", 32'(address), 32'd49);
        reset = 1'b0;
        tick();
        check("midrst_address", 32'(address), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        reset = 1'b1;

        // Random programs and handshake traffic.
        halt_cycles = 0;
        for (int c = 0; c < 6000; c++) begin
            if (halt_cycles > 4 || $urandom_range(0, 299) == 0) begin
                for (int i = 0; i < 1024; i++) ram[i] = rand_word();
                reset = 1'b0;
                halt_cycles = 0;
            end else begin
                reset = 1'b1;
            end
            stall      = ($urandom_range(0, 3) == 0);
            flag_valid = ($urandom_range(0, 4) == 0);
            flag_zero  = $urandom_range(0, 1) == 1;
            input_done = ($urandom_range(0, 4) == 0);
            tick();
            if (m_halted) halt_cycles++;
        end
        reset = 1'b1; stall = 1'b0; flag_valid = 1'b0; input_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
